// File: rtl/ppu_pkg.sv
// Shared raster geometry and dot/line constants for the PPU timing logic.
package ppu_pkg;

   localparam int unsigned CNT_W = 10;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t DOTS_PER_LINE   = 10'd341;
   localparam cnt_t LINES_PER_FRAME = 10'd262;
   localparam cnt_t VISIBLE_LINES   = 10'd240;
   localparam cnt_t VBLANK_LINE     = 10'd241;
   localparam cnt_t PRERENDER_LINE  = 10'd261;

   localparam cnt_t LAST_DOT  = DOTS_PER_LINE - 10'd1;
   localparam cnt_t LAST_LINE = LINES_PER_FRAME - 10'd1;
   localparam cnt_t SKIP_DOT  = LAST_DOT - 10'd1;

   localparam cnt_t FLAG_DOT        = 10'd1;
   localparam cnt_t HORI_INC_FIRST  = 10'd7;
   localparam cnt_t HORI_INC_LAST   = 10'd255;
   localparam cnt_t VERT_INC_DOT    = 10'd256;
   localparam cnt_t HORI_COPY_DOT   = 10'd257;
   localparam cnt_t VERT_COPY_FIRST = 10'd280;
   localparam cnt_t VERT_COPY_LAST  = 10'd304;
   localparam cnt_t PREFETCH_FIRST  = 10'd321;
   localparam cnt_t PREFETCH_LAST   = 10'd335;

   function automatic logic in_range(input cnt_t v, input cnt_t lo, input cnt_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/ppu_dot_counter.sv
// Dot/scanline raster counter with frame parity and the odd-frame short-line jump.
module ppu_dot_counter
   import ppu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             skip,
   output logic [CNT_W-1:0] x_idx,
   output logic [CNT_W-1:0] scanline,
   output logic             frame_odd
);

   cnt_t x_q, x_d;
   cnt_t line_q, line_d;
   logic odd_q, odd_d;

   always_comb begin
      x_d    = x_q + 10'd1;
      line_d = line_q;
      odd_d  = odd_q;
      if (skip) begin
         // Drop the last dot of the pre-render line and start the next frame.
         x_d    = '0;
         line_d = '0;
         odd_d  = ~odd_q;
      end else if (x_q == LAST_DOT) begin
         x_d = '0;
         if (line_q == LAST_LINE) begin
            line_d = '0;
            odd_d  = ~odd_q;
         end else begin
            line_d = line_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q    <= '0;
         line_q <= '0;
         odd_q  <= 1'b0;
      end else begin
         x_q    <= x_d;
         line_q <= line_d;
         odd_q  <= odd_d;
      end
   end

   assign x_idx     = x_q;
   assign scanline  = line_q;
   assign frame_odd = odd_q;

endmodule

// File: rtl/ppu_timing_ctrl.sv
// PPU master sequencer: raster counters, loopy v/t scroll strobes, vblank flag and NMI.
module ppu_timing_ctrl
   import ppu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             show_bg,
   input  logic             show_spr,
   input  logic             nmi_enable,
   input  logic             status_read,
   output logic [CNT_W-1:0] x_idx,
   output logic [CNT_W-1:0] scanline,
   output logic             vblank,
   output logic             nmi,
   output logic             rendering,
   output logic             frame_odd,
   output logic             inc_hori,
   output logic             inc_vert,
   output logic             copy_hori,
   output logic             copy_vert,
   output logic             clr_spr_flags
);

   logic enabled;
   logic prerender;
   logic skip;
   logic vblank_set, vblank_clr;
   logic vblank_q, vblank_d;
   logic nmi_q;

   assign enabled = show_bg | show_spr;
   // Enables are sampled live at dot 339, so a mid-line change still decides the skip.
   assign skip = prerender && (x_idx == SKIP_DOT) && frame_odd && enabled;

   ppu_dot_counter u_dot_counter (
      .clk       (clk),
      .reset     (reset),
      .skip      (skip),
      .x_idx     (x_idx),
      .scanline  (scanline),
      .frame_odd (frame_odd)
   );

   assign prerender = (scanline == PRERENDER_LINE);
   assign rendering = ((scanline < VISIBLE_LINES) || prerender) && enabled;

   assign inc_hori = rendering && (x_idx[2:0] == 3'd7) &&
                     (in_range(x_idx, HORI_INC_FIRST, HORI_INC_LAST) ||
                      in_range(x_idx, PREFETCH_FIRST, PREFETCH_LAST));
   assign inc_vert  = rendering && (x_idx == VERT_INC_DOT);
   assign copy_hori = rendering && (x_idx == HORI_COPY_DOT);
   assign copy_vert = rendering && prerender &&
                      in_range(x_idx, VERT_COPY_FIRST, VERT_COPY_LAST);
   assign clr_spr_flags = prerender && (x_idx == FLAG_DOT);

   assign vblank_set = (scanline == VBLANK_LINE) && (x_idx == FLAG_DOT);
   assign vblank_clr = clr_spr_flags || status_read;

   // A $2002 read coinciding with the set dot suppresses the flag for the frame.
   always_comb begin
      vblank_d = vblank_q;
      if (vblank_clr) begin
         vblank_d = 1'b0;
      end else if (vblank_set) begin
         vblank_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vblank_q <= 1'b0;
         nmi_q    <= 1'b0;
      end else begin
         vblank_q <= vblank_d;
         nmi_q    <= vblank_q & nmi_enable;
      end
   end

   assign vblank = vblank_q;
   assign nmi    = nmi_q;

endmodule
